// File: rtl/eka_icache.sv
// Direct-mapped read-only instruction cache: combinational hits, word-by-word line refill.
// Define EKA_ICACHE_STATS_EN to add the hit_count / miss_count outputs.
module eka_icache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rd_data,
`ifdef EKA_ICACHE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  output logic                  dbg_state
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W - 2;
  localparam int BASE_W = TAG_W + IDX_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES][WORDS_PER_LINE];
  logic [BASE_W-1:0]       base_q, base_d;
  logic [OFF_W-1:0]        beat_q, beat_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

  logic [OFF_W-1:0]        req_word;
  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        fill_idx;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    last_beat;
  logic                    hit;
  logic                    miss_ev;
  logic                    fill_we;
  logic                    tag_we;
  logic                    unused_addr_bits;

  assign req_word         = inst_addr[OFF_W+1:2];
  assign req_idx          = inst_addr[OFF_W+2 +: IDX_W];
  assign req_tag          = inst_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_addr_bits = ^inst_addr[1:0];
  assign fill_idx         = base_q[IDX_W-1:0];
  assign beat_addr        = {base_q, beat_q, 2'b00};
  assign last_beat        = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  assign dbg_state        = (state_q == REFILL);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    base_d       = base_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    mem_addr_d   = mem_addr_q;
    fill_we      = 1'b0;
    tag_we       = 1'b0;
    hit          = 1'b0;
    miss_ev      = 1'b0;
    inst_valid   = 1'b0;
    instruction  = NOP;
    mem_req      = 1'b0;
    mem_addr     = mem_addr_q;
    case (state_q)
      IDLE: begin
        hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        if (hit) begin
          inst_valid  = 1'b1;
          instruction = data_q[req_idx][req_word];
        end else begin
          miss_ev      = 1'b1;
          state_d      = REFILL;
          base_d       = {req_tag, req_idx};
          beat_d       = '0;
          flush_pend_d = 1'b0;
        end
        // The hit above is still returned; invalidation lands at the edge.
        if (flush) valid_d = '0;
      end
      REFILL: begin
        mem_req    = 1'b1;
        mem_addr   = beat_addr;
        mem_addr_d = beat_addr;
        if (flush) begin
          valid_d      = '0;
          flush_pend_d = 1'b1;
        end
        if (mem_ack) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (last_beat) begin
            // A flush seen at any point of the refill leaves the line invalid.
            tag_we            = 1'b1;
            valid_d[fill_idx] = !flush_pend_q && !flush;
            state_d           = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      base_q       <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_we) data_q[fill_idx][beat_q] <= mem_rd_data;
    if (tag_we)  tag_q[fill_idx]          <= base_q[BASE_W-1:IDX_W];
  end

`ifdef EKA_ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + 32'(hit);
    miss_count_d = miss_count_q + 32'(miss_ev);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_eka_icache.sv
// Bench for eka_icache: directed vector table, corner sequences and randomized traffic
// checked against a line-level cache model with an expected refill-address queue.
module tb_eka_icache;

  localparam int LINES      = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        flush;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rd_data;
  logic        dbg_state;
`ifdef EKA_ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  eka_icache #(
    .ADDR_WIDTH    (32),
    .LINES         (LINES),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_addr  (inst_addr),
    .flush      (flush),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rd_data(mem_rd_data),
`ifdef EKA_ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int ack_mode = 0;   // 0 zero-wait, 1 every third request cycle, 2 random
  int wcnt = 0;

  // reference model: which line base each index holds, plus refill scoreboard
  logic [31:0] m_line  [LINES];
  bit          m_valid [LINES];
  bit          m_busy;
  bit          m_discard;
  int          m_fill_idx;
  logic [31:0] m_fill_base;
  logic [31:0] m_last_maddr;
  int          m_hits;
  int          m_misses;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic        exp_req;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_busy       = 1'b0;
    m_discard    = 1'b0;
    exp_q.delete();
    m_last_maddr = 32'h0;
    m_hits       = 0;
    m_misses     = 0;
  endtask

  task automatic clear_lines();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // compare the current cycle's outputs, then advance the model past the edge
  task automatic model_check(input logic [31:0] a, input logic f);
    int          idx;
    logic [31:0] base;
    bit          hit;
    chk("dbg_state", {31'b0, dbg_state}, {31'b0, m_busy});
`ifdef EKA_ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif
    if (!m_busy) begin
      idx  = int'((a / LINE_BYTES) % LINES);
      base = a - (a % LINE_BYTES);
      hit  = m_valid[idx] && (m_line[idx] == base);
      chk("idle_valid", {31'b0, inst_valid}, {31'b0, hit});
      chk("idle_instr", instruction, hit ? (a & ~32'h3) : 32'h13);
      chk("idle_req", {31'b0, mem_req}, 32'h0);
      chk("idle_maddr_hold", mem_addr, m_last_maddr);
      if (hit) m_hits++;
      else begin
        m_misses++;
        m_busy      = 1'b1;
        m_discard   = 1'b0;
        m_fill_idx  = idx;
        m_fill_base = base;
        for (int k = 0; k < WPL; k++) exp_q.push_back(base + 32'(4 * k));
      end
      if (f) clear_lines();
    end else begin
      chk("refill_valid", {31'b0, inst_valid}, 32'h0);
      chk("refill_instr", instruction, 32'h13);
      chk("refill_req", {31'b0, mem_req}, 32'h1);
      chk("refill_maddr", mem_addr, exp_q[0]);
      m_last_maddr = exp_q[0];
      if (f) begin
        clear_lines();
        m_discard = 1'b1;
      end
      if (mem_ack) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          if (!m_discard) begin
            m_valid[m_fill_idx] = 1'b1;
            m_line[m_fill_idx]  = m_fill_base;
          end
        end
      end
    end
  endtask

  // driver: one clock cycle of core address, flush and memory response
  task automatic step(input logic [31:0] a, input logic f);
    @(negedge clk);
    inst_addr = a;
    flush     = f;
    if (mem_req) begin
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1: begin
          mem_ack = (wcnt % 3 == 2);
          wcnt++;
        end
        default: mem_ack = ($urandom_range(0, 2) == 0);
      endcase
    end else begin
      mem_ack = (ack_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
    mem_rd_data = mem_addr & ~32'h3;
    #1;
    model_check(a, f);
  endtask

  task automatic fill_line(input logic [31:0] base, input string name);
    for (int k = 0; k < WPL; k++) begin
      step(base, 1'b0);
      chk({name, "_req"}, {31'b0, mem_req}, 32'h1);
      chk({name, "_maddr"}, mem_addr, base + 32'(4 * k));
    end
  endtask

  task automatic finish_refill(input logic [31:0] a, output int cycles);
    cycles = 0;
    for (int g = 0; g < 80; g++) begin
      step(a, 1'b0);
      if (!mem_req) break;
      cycles++;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, LINES - 1)) << 4) |
        (32'($urandom_range(0, WPL - 1)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) r = r | 32'h8000_0000;
    return r;
  endfunction

  initial begin
    int          cyc;
    logic [31:0] cur;
    logic        f;

    reset       = 1'b0;
    inst_addr   = 32'h0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rd_data = 32'h0;
    model_reset();

    // cold miss of 0x0 followed by sequential hits, zero-wait memory
    tbl[0] = '{32'h0, 1'b0, 1'b0, 32'h13, 1'b0, 32'h0};
    tbl[1] = '{32'h0, 1'b0, 1'b0, 32'h13, 1'b1, 32'h0};
    tbl[2] = '{32'h0, 1'b0, 1'b0, 32'h13, 1'b1, 32'h4};
    tbl[3] = '{32'h0, 1'b0, 1'b0, 32'h13, 1'b1, 32'h8};
    tbl[4] = '{32'h0, 1'b0, 1'b0, 32'h13, 1'b1, 32'hC};
    tbl[5] = '{32'h0, 1'b0, 1'b1, 32'h0,  1'b0, 32'hC};
    tbl[6] = '{32'h4, 1'b0, 1'b1, 32'h4,  1'b0, 32'hC};
    tbl[7] = '{32'h8, 1'b0, 1'b1, 32'h8,  1'b0, 32'hC};
    tbl[8] = '{32'hD, 1'b0, 1'b1, 32'hC,  1'b0, 32'hC};
    tbl[9] = '{32'hC, 1'b0, 1'b1, 32'hC,  1'b0, 32'hC};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset_instr", instruction, 32'h13);
    chk("reset_req", {31'b0, mem_req}, 32'h0);
    chk("reset_maddr", mem_addr, 32'h0);
    chk("reset_state", {31'b0, dbg_state}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].addr, tbl[i].flush);
      chk($sformatf("tbl%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].exp_instr);
      chk($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].exp_maddr);
    end
`ifdef EKA_ICACHE_STATS_EN
    step(32'hC, 1'b0);
    chk("stats_hits", hit_count, 32'd5);
    chk("stats_misses", miss_count, 32'd1);
`endif

    // conflict: 0x100 and 0x0 share index 0
    step(32'h100, 1'b0);
    chk("conf_miss_100", {31'b0, inst_valid}, 32'h0);
    fill_line(32'h100, "conf_fill_100");
    step(32'h104, 1'b0);
    chk("conf_hit_100", {31'b0, inst_valid}, 32'h1);
    chk("conf_data_100", instruction, 32'h104);
    step(32'h0, 1'b0);
    chk("conf_miss_0", {31'b0, inst_valid}, 32'h0);
    fill_line(32'h0, "conf_fill_0");
    step(32'h8, 1'b0);
    chk("conf_hit_0", {31'b0, inst_valid}, 32'h1);
    chk("conf_data_0", instruction, 32'h8);

    // wait states: ack every third request cycle
    ack_mode = 1;
    wcnt     = 0;
    step(32'h1C4, 1'b0);
    chk("ws_miss", {31'b0, inst_valid}, 32'h0);
    finish_refill(32'h1C4, cyc);
    chk("ws_cycles", 32'(cyc), 32'd12);
    chk("ws_valid", {31'b0, inst_valid}, 32'h1);
    chk("ws_data", instruction, 32'h1C4);
    ack_mode = 0;

    // flush during beat 2 of a refill
    step(32'h340, 1'b0);
    chk("fl_miss", {31'b0, inst_valid}, 32'h0);
    step(32'h340, 1'b0);
    step(32'h340, 1'b0);
    step(32'h340, 1'b1);
    chk("fl_beat2_maddr", mem_addr, 32'h348);
    step(32'h340, 1'b0);
    chk("fl_beat3_maddr", mem_addr, 32'h34C);
    step(32'h340, 1'b0);
    chk("fl_after_valid", {31'b0, inst_valid}, 32'h0);
    chk("fl_after_req", {31'b0, mem_req}, 32'h0);
    step(32'h340, 1'b0);
    chk("fl_rerefill_req", {31'b0, mem_req}, 32'h1);
    chk("fl_rerefill_maddr", mem_addr, 32'h340);
    finish_refill(32'h340, cyc);
    chk("fl_final_valid", {31'b0, inst_valid}, 32'h1);
    chk("fl_final_data", instruction, 32'h340);

    // reset during beat 1 of a refill
    step(32'h2A8, 1'b0);
    chk("rs_miss", {31'b0, inst_valid}, 32'h0);
    step(32'h2A8, 1'b0);
    step(32'h2A8, 1'b0);
    chk("rs_beat1_maddr", mem_addr, 32'h2A4);
    reset = 1'b0;
    #1;
    chk("rs_req", {31'b0, mem_req}, 32'h0);
    chk("rs_instr", instruction, 32'h13);
    chk("rs_valid", {31'b0, inst_valid}, 32'h0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    step(32'h2A8, 1'b0);
    chk("rs_cold_miss", {31'b0, inst_valid}, 32'h0);
    step(32'h2A8, 1'b0);
    chk("rs_refill_maddr", mem_addr, 32'h2A0);
    finish_refill(32'h2A8, cyc);
    chk("rs_final_valid", {31'b0, inst_valid}, 32'h1);
    chk("rs_final_data", instruction, 32'h2A8);

    // randomized traffic with random wait states, stray acks and flushes
    ack_mode = 2;
    cur      = rand_addr();
    for (int n = 0; n < 2000; n++) begin
      if (!m_busy && $urandom_range(0, 2) != 0) cur = rand_addr();
      f = ($urandom_range(0, 39) == 0);
      step(cur, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
